capture_sequencer: RTL and testbench

- Sequences one acquisition into the 2^AW-deep sample RAM: pre-trigger fill, armed circular write, post-trigger fill, done.
- Sits between the trigger/signal logic and the RAM write port, and drives write enable and write address.
- Reports the trigger address and the oldest-sample address so the read side can unroll the circular buffer.
- Adds a free-run mode and an auto-trigger timeout.

---
 rtl/capture_sequencer.sv | 172 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Acquisition sequencer for a 2^AW-deep circular sample RAM: pre-trigger fill,
// armed circular write, post-trigger fill, done; with free-run and auto-trigger.
module capture_sequencer #(
    parameter int unsigned AW = 12,
    parameter int unsigned TW = 16
) (
    input  logic          MCI,
    input  logic          nClrW,
    input  logic          Arm,
    input  logic          Trig,
    input  logic          FreeRun,
    input  logic          AutoEn,
    input  logic [TW-1:0] AutoTmo,
    input  logic [AW-1:0] PreDepth,
    output logic          Wen,
    output logic [AW-1:0] Waddr,
    output logic [AW-1:0] TrigAddr,
    output logic [AW-1:0] FirstAddr,
    output logic          PreFull,
    output logic          Busy,
    output logic          Ready,
    output logic          AutoFlag,
    output logic [2:0]    State
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] pre_depth_q, pre_depth_d;
    logic [AW:0]   pre_cnt_q, pre_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [AW-1:0] first_addr_q, first_addr_d;
    logic          pre_full_q, pre_full_d;
    logic          auto_flag_q, auto_flag_d;
    logic          wen_q, wen_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;

    logic          auto_hit;
    logic          trig_ev;
    logic [AW:0]   post_len;

    // AutoTmo=0 must fire on the first ARMED cycle, not after the counter wraps
    assign auto_hit = AutoEn & ((AutoTmo == '0) | (tmo_cnt_q == AutoTmo - TW'(1)));
    assign trig_ev  = Trig | FreeRun | auto_hit;
    assign post_len = (AW+1)'(DEPTH) - {1'b0, pre_depth_q};

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        pre_depth_d  = pre_depth_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        trig_addr_d  = trig_addr_q;
        first_addr_d = first_addr_q;
        pre_full_d   = pre_full_q;
        auto_flag_d  = auto_flag_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Arm) begin
                    pre_depth_d  = PreDepth;
                    waddr_d      = '0;
                    pre_cnt_d    = '0;
                    post_cnt_d   = '0;
                    tmo_cnt_d    = '0;
                    trig_addr_d  = '0;
                    first_addr_d = '0;
                    auto_flag_d  = 1'b0;
                    if (PreDepth == '0) begin
                        state_d    = S_ARMED;
                        pre_full_d = 1'b1;
                    end else begin
                        state_d    = S_PRE;
                        pre_full_d = 1'b0;
                    end
                end
            end
            S_PRE: begin
                waddr_d   = waddr_q + AW'(1);
                pre_cnt_d = pre_cnt_q + (AW+1)'(1);
                if (pre_cnt_d == {1'b0, pre_depth_q}) begin
                    state_d    = S_ARMED;
                    pre_full_d = 1'b1;
                end
            end
            S_ARMED: begin
                waddr_d   = waddr_q + AW'(1);
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (trig_ev) begin
                    trig_addr_d  = waddr_q;
                    first_addr_d = waddr_q - pre_depth_q;
                    auto_flag_d  = ~Trig & ~FreeRun;
                    // post length includes the trigger sample written this cycle
                    if (post_len == (AW+1)'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_POST;
                        post_cnt_d = post_len - (AW+1)'(1);
                    end
                end
            end
            S_POST: begin
                waddr_d    = waddr_q + AW'(1);
                post_cnt_d = post_cnt_q - (AW+1)'(1);
                if (post_cnt_q == (AW+1)'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wen_d   = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
        busy_d  = wen_d;
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge MCI or negedge nClrW) begin
        if (!nClrW) begin
            state_q      <= S_IDLE;
            waddr_q      <= '0;
            pre_depth_q  <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            trig_addr_q  <= '0;
            first_addr_q <= '0;
            pre_full_q   <= 1'b0;
            auto_flag_q  <= 1'b0;
            wen_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            pre_depth_q  <= pre_depth_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            trig_addr_q  <= trig_addr_d;
            first_addr_q <= first_addr_d;
            pre_full_q   <= pre_full_d;
            auto_flag_q  <= auto_flag_d;
            wen_q        <= wen_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign Wen       = wen_q;
    assign Waddr     = waddr_q;
    assign TrigAddr  = trig_addr_q;
    assign FirstAddr = first_addr_q;
    assign PreFull   = pre_full_q;
    assign Busy      = busy_q;
    assign Ready     = ready_q;
    assign AutoFlag  = auto_flag_q;
    assign State     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer at AW=4: each scenario checks states,
// addresses, flags and write counts against hand-computed values.
module tb_capture_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned TW = 16;

    logic          MCI = 1'b0;
    logic          nClrW;
    logic          Arm, Trig, FreeRun, AutoEn;
    logic [TW-1:0] AutoTmo;
    logic [AW-1:0] PreDepth;
    logic          Wen, PreFull, Busy, Ready, AutoFlag;
    logic [AW-1:0] Waddr, TrigAddr, FirstAddr;
    logic [2:0]    State;

    int n_vec = 0;
    int n_bad = 0;
    int wr_total = 0;
    int wr_start;

    capture_sequencer #(.AW(AW), .TW(TW)) dut (
        .MCI(MCI), .nClrW(nClrW), .Arm(Arm), .Trig(Trig), .FreeRun(FreeRun),
        .AutoEn(AutoEn), .AutoTmo(AutoTmo), .PreDepth(PreDepth),
        .Wen(Wen), .Waddr(Waddr), .TrigAddr(TrigAddr), .FirstAddr(FirstAddr),
        .PreFull(PreFull), .Busy(Busy), .Ready(Ready), .AutoFlag(AutoFlag),
        .State(State)
    );

    always #5 MCI = ~MCI;

    // Wen seen at the edge is the write that completes on that edge
    always @(posedge MCI) if (Wen) wr_total <= wr_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge MCI);
            #1;
        end
    endtask

    task automatic arm_pulse();
        Arm = 1'b1;
        step(1);
        Arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!Ready && c < budget) begin
            step(1);
            c++;
        end
        check({tag, "_ready"}, 32'(Ready), 1);
    endtask

    initial begin
        nClrW = 1'b0; Arm = 0; Trig = 0; FreeRun = 0; AutoEn = 0;
        AutoTmo = '0; PreDepth = '0;
        step(3);
        check("rst_state", 32'(State), 0);
        check("rst_wen",   32'(Wen), 0);
        check("rst_waddr", 32'(Waddr), 0);
        check("rst_flags", {Busy, Ready, PreFull, AutoFlag}, 0);
        nClrW = 1'b1;
        step(2);
        check("idle_state", 32'(State), 0);

        // Trig pulse 10 cycles into ARMED
        PreDepth = 4'd4;
        arm_pulse();
        wr_start = wr_total;
        check("t1_pre", 32'(State), 1);
        check("t1_pre_wen", 32'(Wen), 1);
        check("t1_pre_full0", 32'(PreFull), 0);
        step(4);
        check("t1_armed", 32'(State), 2);
        check("t1_prefull", 32'(PreFull), 1);
        check("t1_waddr4", 32'(Waddr), 4);
        step(10);
        check("t1_armed_hold", 32'(State), 2);
        Trig = 1'b1;
        step(1);
        Trig = 1'b0;
        check("t1_post", 32'(State), 3);
        check("t1_trigaddr", 32'(TrigAddr), 14);
        check("t1_firstaddr", 32'(FirstAddr), 10);
        wait_done("t1", 40);
        check("t1_writes", 32'(wr_total - wr_start), 26);
        check("t1_final_waddr", 32'(Waddr), 10);
        check("t1_autoflag", 32'(AutoFlag), 0);
        check("t1_busy_wen", {Busy, Wen}, 0);
        check("t1_done", 32'(State), 4);

        // PreDepth=0 with free-run
        PreDepth = 4'd0;
        FreeRun  = 1'b1;
        arm_pulse();
        wr_start = wr_total;
        check("t2_armed", 32'(State), 2);
        check("t2_prefull", 32'(PreFull), 1);
        step(1);
        check("t2_post", 32'(State), 3);
        check("t2_trigaddr", 32'(TrigAddr), 0);
        check("t2_firstaddr", 32'(FirstAddr), 0);
        FreeRun = 1'b0;
        wait_done("t2", 40);
        check("t2_writes", 32'(wr_total - wr_start), 16);
        check("t2_final_waddr", 32'(Waddr), 0);

        // PreDepth=15 with Trig held: no POST phase
        PreDepth = 4'd15;
        Trig     = 1'b1;
        arm_pulse();
        wr_start = wr_total;
        check("t3_pre", 32'(State), 1);
        step(15);
        check("t3_armed", 32'(State), 2);
        check("t3_waddr15", 32'(Waddr), 15);
        step(1);
        Trig = 1'b0;
        check("t3_done", 32'(State), 4);
        check("t3_trigaddr", 32'(TrigAddr), 15);
        check("t3_firstaddr", 32'(FirstAddr), 0);
        check("t3_writes", 32'(wr_total - wr_start), 16);
        check("t3_final_waddr", 32'(Waddr), 0);

        // Auto-trigger timeout, plus Arm ignored during POST
        PreDepth = 4'd2;
        AutoEn   = 1'b1;
        AutoTmo  = 16'd5;
        arm_pulse();
        wr_start = wr_total;
        step(2);
        check("t4_armed", 32'(State), 2);
        step(4);
        check("t4_armed_hold", 32'(State), 2);
        step(1);
        check("t4_post", 32'(State), 3);
        check("t4_trigaddr", 32'(TrigAddr), 6);
        check("t4_firstaddr", 32'(FirstAddr), 4);
        check("t4_autoflag", 32'(AutoFlag), 1);
        AutoEn = 1'b0;
        arm_pulse();
        check("t5_arm_in_post", 32'(State), 3);
        wait_done("t4", 40);
        check("t4_writes", 32'(wr_total - wr_start), 20);
        check("t4_final_waddr", 32'(Waddr), 4);
        check("t4_autoflag_done", 32'(AutoFlag), 1);

        // Arm and Trig together in DONE: Arm wins
        PreDepth = 4'd3;
        Trig     = 1'b1;
        arm_pulse();
        Trig = 1'b0;
        check("t5_restart", 32'(State), 1);
        check("t5_waddr", 32'(Waddr), 0);
        check("t5_prefull", 32'(PreFull), 0);
        check("t5_clear", {TrigAddr, FirstAddr, 3'b000, AutoFlag}, 0);

        // Asynchronous reset in the middle of ARMED
        step(3);
        check("t6_armed", 32'(State), 2);
        step(2);
        #3 nClrW = 1'b0;
        #1;
        check("t6_rst_state", 32'(State), 0);
        check("t6_rst_wen", 32'(Wen), 0);
        check("t6_rst_outs", {Waddr, TrigAddr, FirstAddr, PreFull, Busy, Ready, AutoFlag}, 0);
        #1 nClrW = 1'b1;
        step(1);
        PreDepth = 4'd1;
        Trig     = 1'b1;
        arm_pulse();
        wr_start = wr_total;
        check("t6_pre", 32'(State), 1);
        step(2);
        Trig = 1'b0;
        check("t6_post", 32'(State), 3);
        check("t6_trigaddr", 32'(TrigAddr), 1);
        check("t6_firstaddr", 32'(FirstAddr), 0);
        wait_done("t6", 40);
        check("t6_writes", 32'(wr_total - wr_start), 16);
        check("t6_final_waddr", 32'(Waddr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
